// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR} state_t;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Clocks per UART bit, rounded to nearest.
   function automatic int bit_period(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// valid pulses one cycle with a good byte; frame_err pulses on a low stop bit.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half a bit in, confirming the start bit is still low
// RX_DATA  | sampling 8 data bits at bit centres, LSB first
// RX_STOP  | sampling the stop bit at its centre
module uart_rx_byte
   import boot_pkg::*;
#(
   parameter int CLK_HZ = 27_000_000,
   parameter int BAUD   = 57_600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int BIT_CYC = bit_period(CLK_HZ, BAUD);
   localparam int CNT_W   = $clog2(BIT_CYC + 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYC / 2 - 1);

   rx_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       idx, idx_nx;
   logic [7:0]       shreg, shreg_nx;
   logic [7:0]       data_nx;
   logic             valid_nx, ferr_nx;
   logic             rx_s1, rx_s2, rx_prev;

   // Bring the asynchronous line into clk and keep one delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RX_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         shreg     <= shreg_nx;
         data      <= data_nx;
         valid     <= valid_nx;
         frame_err <= ferr_nx;
      end
   end

   // Bit timing with a down-counter; every sample happens when it reaches zero.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shreg_nx = shreg;
      data_nx  = data;
      valid_nx = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rx_prev && !rx_s2) begin
               state_nx = RX_START;
               cnt_nx   = HALF_LOAD;
            end
         end
         RX_START: begin
            if (cnt == '0) begin
               if (!rx_s2) begin
                  state_nx = RX_DATA;
                  cnt_nx   = BIT_LOAD;
                  idx_nx   = '0;
               end else begin
                  state_nx = RX_IDLE;
               end
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt == '0) begin
               shreg_nx = {rx_s2, shreg[7:1]};
               cnt_nx   = BIT_LOAD;
               if (idx == 3'd7) state_nx = RX_STOP;
               else             idx_nx   = idx + 3'd1;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt == '0) begin
               state_nx = RX_IDLE;
               if (rx_s2) begin
                  data_nx  = shreg;
                  valid_nx = 1'b1;
               end else begin
                  ferr_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         default: state_nx = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a checksummed word image from UART into BSRAM and releases the CPU once verified.
//
// state | meaning
// IDLE  | hunting for the sync byte, other bytes ignored
// LEN   | next byte is the word count (0 = 256)
// HI    | next byte is the high half of a word
// LO    | next byte is the low half of a word
// WRITE | one-cycle BSRAM write of the assembled word
// CSUM  | next byte is the checksum of all data bytes
// DONE  | image verified, CPU owns BSRAM, terminal until reset
// ERR   | one-cycle transit after a failed frame, back to IDLE
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int CLK_HZ      = 27_000_000,
   parameter int BAUD        = 57_600,
   parameter int ADDR_W      = 11,
   parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              mem_ce,
   output logic              mem_wre,
   output logic [ADDR_W-1:0] mem_ad,
   output logic [15:0]       mem_din,
   output logic              boot_mode,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int WL_W  = ADDR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);

   state_t            state, state_nx;
   logic [7:0]        rx_data;
   logic              rx_valid, rx_ferr;
   logic [ADDR_W-1:0] addr;
   logic [8:0]        len_n;
   logic [7:0]        hi_byte;
   logic [7:0]        csum;
   logic [TMO_W-1:0]  tmo;
   logic              tmo_run, sync_seen, last_word;

   uart_rx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (uart_rx),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   assign mem_ce    = 1'b1;
   assign mem_wre   = (state == WRITE);
   assign boot_mode = (state != DONE);
   assign done      = (state == DONE);
   assign tmo_run   = (state == LEN) || (state == HI) || (state == LO) || (state == CSUM);
   assign sync_seen = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
   assign last_word = (words_loaded + WL_W'(1)) >= WL_W'(len_n);

   // State register; reset drops any in-flight write immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic: normal byte flow, then framing errors and timeout override it.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (sync_seen) state_nx = LEN;
         LEN:     if (rx_valid) state_nx = HI;
         HI:      if (rx_valid) state_nx = LO;
         LO:      if (rx_valid) state_nx = WRITE;
         WRITE:   state_nx = last_word ? CSUM : HI;
         CSUM:    if (rx_valid) state_nx = (rx_data == csum) ? DONE : ERR;
         DONE:    state_nx = DONE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (tmo_run || state == WRITE) begin
         if (rx_ferr)                               state_nx = ERR;
         else if (tmo_run && !rx_valid && tmo == '0) state_nx = ERR;
      end
   end

   // Sticky error flag: set on entry to ERR, cleared by the next sync byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  err <= 1'b0;
      else if (state_nx == ERR) err <= 1'b1;
      else if (sync_seen)       err <= 1'b0;
   end

   // Frame datapath: length, word assembly, checksum, address and inter-byte timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr         <= '0;
         words_loaded <= '0;
         len_n        <= '0;
         hi_byte      <= '0;
         csum         <= '0;
         mem_ad       <= '0;
         mem_din      <= '0;
         tmo          <= TMO_LOAD;
      end else begin
         if (rx_valid)                     tmo <= TMO_LOAD;
         else if (tmo_run && tmo != '0)    tmo <= tmo - TMO_W'(1);
         case (state)
            IDLE: begin
               if (sync_seen) begin
                  addr         <= '0;
                  words_loaded <= '0;
                  csum         <= '0;
               end
            end
            LEN: begin
               if (rx_valid) len_n <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            end
            HI: begin
               if (rx_valid) begin
                  hi_byte <= rx_data;
                  csum    <= csum + rx_data;
               end
            end
            LO: begin
               if (rx_valid) begin
                  csum    <= csum + rx_data;
                  mem_ad  <= addr;
                  mem_din <= {hi_byte, rx_data};
               end
            end
            WRITE: begin
               addr         <= addr + ADDR_W'(1);
               words_loaded <= words_loaded + WL_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serial frames in, BSRAM writes and status out.
module tb_uart_boot_loader;

   localparam int CLK_HZ  = 1_000_000;
   localparam int BAUD    = 100_000;
   localparam int BIT     = 10;
   localparam int ADDR_W  = 11;
   localparam int TMO_CYC = 300;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              uart_rx = 1'b1;
   logic              mem_ce, mem_wre, boot_mode, done, err;
   logic [ADDR_W-1:0] mem_ad;
   logic [15:0]       mem_din;
   logic [ADDR_W:0]   words_loaded;

   typedef struct {
      logic [ADDR_W-1:0] ad;
      logic [15:0]       din;
   } wr_t;

   wr_t wq[$];
   int  n_chk = 0;
   int  n_bad = 0;

   uart_boot_loader #(
      .CLK_HZ      (CLK_HZ),
      .BAUD        (BAUD),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TMO_CYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rx      (uart_rx),
      .mem_ce       (mem_ce),
      .mem_wre      (mem_wre),
      .mem_ad       (mem_ad),
      .mem_din      (mem_din),
      .boot_mode    (boot_mode),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Record every write pulse mid-cycle.
   always @(negedge clk) begin
      if (mem_wre) wq.push_back('{ad: mem_ad, din: mem_din});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      uart_rx = v;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_v);
      uart_rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wq.delete();
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [ADDR_W-1:0] ad,
                         input logic [15:0] din);
      if (wq.size() > idx) begin
         chk({tag, "_ad"}, 32'(wq[idx].ad), 32'(ad));
         chk({tag, "_din"}, 32'(wq[idx].din), 32'(din));
      end else begin
         chk({tag, "_present"}, 32'(wq.size()), 32'(idx + 1));
      end
   endtask

   // Checksum of 12 34 AB CD is 0x1BE mod 256 = 0xBE.
   initial begin
      logic hit;
      @(negedge clk);
      do_reset();
      chk("rst_ce", 32'(mem_ce), 1);
      chk("rst_wre", 32'(mem_wre), 0);
      chk("rst_ad", 32'(mem_ad), 0);
      chk("rst_din", 32'(mem_din), 0);
      chk("rst_boot", 32'(boot_mode), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_words", 32'(words_loaded), 0);

      // Two-word good frame
      send_frame('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
      chk("f1_nwr", 32'(wq.size()), 2);
      chk_wr("f1_w0", 0, 11'd0, 16'h1234);
      chk_wr("f1_w1", 1, 11'd1, 16'hABCD);
      chk("f1_done", 32'(done), 1);
      chk("f1_boot", 32'(boot_mode), 0);
      chk("f1_words", 32'(words_loaded), 2);
      chk("f1_err", 32'(err), 0);

      // Bad checksum, then a good resend
      do_reset();
      send_frame('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h6F});
      chk("f2_nwr", 32'(wq.size()), 2);
      chk("f2_err", 32'(err), 1);
      chk("f2_boot", 32'(boot_mode), 1);
      chk("f2_done", 32'(done), 0);
      send_byte(8'hA5);
      chk("f2_err_clr", 32'(err), 0);
      chk("f2_words_clr", 32'(words_loaded), 0);
      send_frame('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
      chk("f2_done2", 32'(done), 1);
      chk("f2_nwr2", 32'(wq.size()), 4);

      // Garbage before sync
      do_reset();
      send_frame('{8'h00, 8'hFF, 8'h5A});
      chk("f3_garbage_nwr", 32'(wq.size()), 0);
      send_frame('{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07});
      chk("f3_nwr", 32'(wq.size()), 1);
      chk_wr("f3_w0", 0, 11'd0, 16'h0007);
      chk("f3_done", 32'(done), 1);
      chk("f3_words", 32'(words_loaded), 1);

      // Inter-byte timeout after one word of three
      do_reset();
      send_frame('{8'hA5, 8'h03, 8'h11, 8'h22});
      repeat (TMO_CYC + 100) @(negedge clk);
      chk("f4_err", 32'(err), 1);
      chk("f4_nwr", 32'(wq.size()), 1);
      chk_wr("f4_w0", 0, 11'd0, 16'h1122);
      chk("f4_words", 32'(words_loaded), 1);
      chk("f4_boot", 32'(boot_mode), 1);
      send_frame('{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07});
      chk("f4_done", 32'(done), 1);
      chk("f4_nwr2", 32'(wq.size()), 2);

      // Framing error: ignored in IDLE, fatal to the frame during HI
      do_reset();
      send_byte(8'hA5, 1'b0);
      chk("f5_idle_err", 32'(err), 0);
      chk("f5_idle_nwr", 32'(wq.size()), 0);
      send_frame('{8'hA5, 8'h02});
      send_byte(8'h12, 1'b0);
      chk("f5_hi_err", 32'(err), 1);
      send_byte(8'h34);
      chk("f5_hi_nwr", 32'(wq.size()), 0);
      chk("f5_boot", 32'(boot_mode), 1);

      // Reset in the middle of a WRITE cycle
      do_reset();
      send_frame('{8'hA5, 8'h01, 8'h00});
      hit = 1'b0;
      fork
         send_byte(8'h07);
      join_none
      for (int k = 0; k < 40 * BIT && !hit; k++) begin
         @(negedge clk);
         if (mem_wre) hit = 1'b1;
      end
      chk("f6_wre_seen", 32'(hit), 1);
      rst = 1'b1;
      #1;
      chk("f6_rst_wre", 32'(mem_wre), 0);
      chk("f6_rst_ad", 32'(mem_ad), 0);
      chk("f6_rst_din", 32'(mem_din), 0);
      chk("f6_rst_words", 32'(words_loaded), 0);
      chk("f6_rst_boot", 32'(boot_mode), 1);
      wait fork;
      do_reset();

      // After DONE, further frames are ignored
      send_frame('{8'hA5, 8'h01, 8'h00, 8'h07, 8'h07});
      chk("f7_done", 32'(done), 1);
      wq.delete();
      send_frame('{8'hA5, 8'h01, 8'h00, 8'h09, 8'h09});
      chk("f7_nwr", 32'(wq.size()), 0);
      chk("f7_din_hold", 32'(mem_din), 32'h0007);
      chk("f7_done_hold", 32'(done), 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
